// File: rtl/intc_pkg.sv
// intc_pkg: register map and constants shared by the interrupt controller.
package intc_pkg;
  typedef enum logic [1:0] {PENDING, ENABLE, EDGE, CLAIM} intc_reg_e;
  localparam int CLAIM_VALID_BIT = 31;
  localparam int MAX_SRC = 31;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_q, r_meta} <= 2'b00;
    else     {r_q, r_meta} <= {r_meta, d};
  assign q = r_q;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller driving the CU hwint line.
// INT_CTRL_SYNC_EN defined inserts a two-flop synchroniser on every irq bit.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [1:0]         addr,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               hwint
);
  logic [NUM_SRC-1:0] r_pend, r_en, r_edge, r_prev;
  logic [31:0]        r_rdata;
  logic               r_hwint;
  logic [NUM_SRC-1:0] w_irq_s, w_wd, w_clr, w_rise, w_pend_nx;
  logic [5:0]         w_claim;
  logic [31:0]        w_claim_word, w_rmux;
  intc_reg_e          w_reg;
  function automatic logic [5:0] f_claim(input logic [NUM_SRC-1:0] v);
    f_claim = '0;
    for (int n = NUM_SRC - 1; n >= 0; n--)
      if (v[n]) f_claim = {1'b1, 5'(n)};
  endfunction
`ifdef INT_CTRL_SYNC_EN
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    sync_2ff u_sync (.clk(clk), .rst(rst), .d(irq[i]), .q(w_irq_s[i]));
  end
`else
  assign w_irq_s = irq;
`endif
  assign w_reg   = intc_reg_e'(addr);
  assign w_wd    = NUM_SRC'(wdata);
  assign w_claim = f_claim(r_pend & r_en);
  assign w_rise  = w_irq_s & ~r_prev;
  // Leaving edge mode drops the latched bit so level sampling starts clean.
  assign w_clr = ({NUM_SRC{wr && w_reg == PENDING}} & w_wd)
               | ({NUM_SRC{wr && w_reg == EDGE}} & r_edge & ~w_wd)
               | ({NUM_SRC{rd && w_reg == CLAIM && w_claim[5]}} & (NUM_SRC'(1) << w_claim[4:0]));
  assign w_pend_nx = (r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & w_irq_s);
  always_comb begin
    w_claim_word = '0;
    w_claim_word[4:0] = w_claim[4:0];
    w_claim_word[CLAIM_VALID_BIT] = w_claim[5];
  end
  assign w_rmux = w_reg == PENDING ? 32'(r_pend)
                : w_reg == ENABLE  ? 32'(r_en)
                : w_reg == EDGE    ? 32'(r_edge)
                :                    w_claim_word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend  <= '0;
      r_en    <= '0;
      r_edge  <= '0;
      r_prev  <= '0;
      r_rdata <= '0;
      r_hwint <= 1'b0;
    end else begin
      r_prev  <= w_irq_s;
      r_pend  <= w_pend_nx;
      r_hwint <= |(r_pend & r_en);
      if (wr && w_reg == ENABLE) r_en <= w_wd;
      if (wr && w_reg == EDGE) r_edge <= w_wd;
      if (rd) r_rdata <= w_rmux;
    end
  assign rdata = r_rdata;
  assign hwint = r_hwint;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl; reads queue their expected value on issue.
module tb_int_ctrl;
  import intc_pkg::*;
`ifdef INT_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic [1:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hwint;
  logic [31:0] sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .irq(irq), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .hwint(hwint)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr_reg(input intc_reg_e a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    step(1);
    wr = 1'b0;
  endtask
  task automatic rd_reg(input string tag, input intc_reg_e a, input logic [31:0] exp);
    addr = a; rd = 1'b1;
    sb_q.push_back(exp);
    step(1);
    rd = 1'b0;
    chk(tag, rdata, sb_q.pop_front());
  endtask
  initial begin
    step(2);
    chk("rst_hwint", 32'(hwint), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    // 1: level sources pend while disabled, enable raises hwint
    irq = 8'hFF;
    step(SL + 1);
    chk("t1_hw_dis", 32'(hwint), 0);
    rd_reg("t1_pend", PENDING, 32'h0000_00FF);
    chk("t1_hw_dis2", 32'(hwint), 0);
    wr_reg(ENABLE, 32'h0000_0004);
    chk("t1_hw_early", 32'(hwint), 0);
    step(1);
    chk("t1_hw_en", 32'(hwint), 1);
    irq = '0;
    wr_reg(EDGE, 32'hFFFF_FFFF);
    wr_reg(ENABLE, 32'hFFFF_FFFF);
    step(SL + 2);
    chk("t1_hw_clr", 32'(hwint), 0);
    rd_reg("t1_en_rd", ENABLE, 32'h0000_00FF);
    // 2: one-cycle edge pulse, claim acknowledges
    irq = 8'h20;
    step(1);
    irq = '0;
    step(SL);
    chk("t2_hw_lat", 32'(hwint), 0);
    step(1);
    chk("t2_hw", 32'(hwint), 1);
    rd_reg("t2_claim", CLAIM, 32'h8000_0005);
    rd_reg("t2_pend", PENDING, 32'h0);
    chk("t2_hw_off", 32'(hwint), 0);
    // 3: simultaneous edges are claimed lowest index first
    irq = 8'h44;
    step(1);
    irq = '0;
    step(SL + 1);
    rd_reg("t3_claim2", CLAIM, 32'h8000_0002);
    rd_reg("t3_claim6", CLAIM, 32'h8000_0006);
    rd_reg("t3_claim0", CLAIM, 32'h0);
    chk("t3_hw_off", 32'(hwint), 0);
    // 4: new edge on the claim edge is kept
    irq = 8'h08;
    step(1);
    irq = '0;
    step(SL + 1);
    chk("t4_hw", 32'(hwint), 1);
    irq = 8'h08;
    step(SL);
    rd_reg("t4_claim", CLAIM, 32'h8000_0003);
    irq = '0;
    rd_reg("t4_pend", PENDING, 32'h0000_0008);
    chk("t4_hw_held", 32'(hwint), 1);
    wr_reg(PENDING, 32'h0000_0008);
    step(1);
    chk("t4_hw_w1c", 32'(hwint), 0);
    // 5: level source is not cleared by claim
    wr_reg(EDGE, 32'h0000_00FD);
    irq = 8'h02;
    step(SL + 2);
    chk("t5_hw", 32'(hwint), 1);
    rd_reg("t5_claim", CLAIM, 32'h8000_0001);
    rd_reg("t5_pend", PENDING, 32'h0000_0002);
    irq = '0;
    step(SL + 1);
    rd_reg("t5_pend0", PENDING, 32'h0);
    chk("t5_hw_off", 32'(hwint), 0);
    // edge-to-level switch drops the latched bit; rd+wr returns pre-write value
    irq = 8'h10;
    step(1);
    irq = '0;
    step(SL + 1);
    wr_reg(EDGE, 32'h0000_00ED);
    rd_reg("sw_pend", PENDING, 32'h0);
    rd_reg("sw_edge", EDGE, 32'h0000_00ED);
    addr = ENABLE; wdata = 32'h0000_000F; rd = 1'b1; wr = 1'b1;
    sb_q.push_back(32'h0000_00FF);
    step(1);
    rd = 1'b0; wr = 1'b0;
    chk("rdwr_old", rdata, sb_q.pop_front());
    rd_reg("rdwr_new", ENABLE, 32'h0000_000F);
    // 6: async reset clears everything immediately
    wr_reg(ENABLE, 32'h0000_00FF);
    wr_reg(EDGE, 32'h0000_00FF);
    irq = 8'h10;
    step(1);
    irq = '0;
    step(SL + 1);
    rd_reg("t6_pend", PENDING, 32'h0000_0010);
    chk("t6_hw", 32'(hwint), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_hw", 32'(hwint), 0);
    chk("t6_rst_rd", rdata, 0);
    step(1);
    rst = 1'b0;
    rd_reg("t6_rst_pend", PENDING, 32'h0);
    rd_reg("t6_rst_en", ENABLE, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
